// File: rtl/fir_coeff_loader_pkg.sv
// fir_coeff_loader_pkg: shared state encoding and tap-count helpers for the coefficient loader and filter wrapper
package fir_coeff_loader_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_PRIME, ST_STREAM, ST_DONE} state_t;
    function automatic int n_load(input int num_coeffs, input int symmetric);
        return (symmetric != 0) ? (num_coeffs + 1) / 2 : num_coeffs;
    endfunction
    function automatic int addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/fir_coeff_loader_if.sv
// fir_coeff_loader_if: config write/commit port and reload AXI-Stream between software, loader and filter
interface fir_coeff_loader_if #(
    parameter int COEFF_WIDTH = 16,
    parameter int AW = 9
);
    logic                   cfg_wr_en;
    logic [AW-1:0]          cfg_wr_addr;
    logic [COEFF_WIDTH-1:0] cfg_wr_data;
    logic                   cfg_commit;
    logic                   cfg_wr_err;
    logic                   busy;
    logic                   done;
    logic [COEFF_WIDTH-1:0] reload_tdata;
    logic                   reload_tvalid;
    logic                   reload_tlast;
    logic                   reload_tready;
    modport master (
        input  cfg_wr_en, cfg_wr_addr, cfg_wr_data, cfg_commit, reload_tready,
        output cfg_wr_err, busy, done, reload_tdata, reload_tvalid, reload_tlast
    );
    modport slave (
        output cfg_wr_en, cfg_wr_addr, cfg_wr_data, cfg_commit, reload_tready,
        input  cfg_wr_err, busy, done, reload_tdata, reload_tvalid, reload_tlast
    );
endinterface

// File: rtl/fir_coeff_loader_ram_2port.sv
// ram_2port: shadow tap memory with a write port and a registered, enable-gated read port, preloaded with power-on taps
module ram_2port #(
    parameter int W = 16,
    parameter int DEPTH = 512,
    parameter int AW = 9,
    parameter int NUM_COEFFS = 1024,
    parameter logic [NUM_COEFFS*W-1:0] INIT_VEC = '0
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [DEPTH];
    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        logic [W-1:0] word = INIT_VEC[(NUM_COEFFS-1-i)*W +: W];
        always_ff @(posedge clk) begin
            if (we && waddr == AW'(i)) word <= wdata;
        end
        assign mem[i] = word;
    end
    // Read register doubles as the stream data register, so it holds while re is low
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/fir_coeff_loader.sv
// fir_coeff_loader: shadow tap store that streams the full tap set to the FIR reload port on commit or after reset
module fir_coeff_loader
    import fir_coeff_loader_pkg::*;
#(
    parameter int COEFF_WIDTH = 16,
    parameter int NUM_COEFFS = 1024,
    parameter int SYMMETRIC = 1,
    parameter logic [NUM_COEFFS*COEFF_WIDTH-1:0] COEFFS_VEC =
        {1'b0, {(COEFF_WIDTH-1){1'b1}}, {((NUM_COEFFS-1)*COEFF_WIDTH){1'b0}}},
    parameter int AUTO_LOAD = 1
) (
    input logic                clk,
    input logic                reset_n,
    fir_coeff_loader_if.master bus
);
    localparam int N_LOAD = n_load(NUM_COEFFS, SYMMETRIC);
    localparam int AW = addr_width(N_LOAD);
    state_t        state;
    logic          pending;
    logic          auto_q;
    logic [AW-1:0] rd_addr;
    logic [AW-1:0] raddr;
    logic          hs;
    logic          wr_ok;
    logic          re;
    assign hs = bus.reload_tvalid && bus.reload_tready;
    assign wr_ok = bus.cfg_wr_en && state == ST_IDLE && {1'b0, bus.cfg_wr_addr} < (AW+1)'(N_LOAD);
    // Next read only once the presented beat is taken, so data holds through stalls
    assign re = state == ST_PRIME || (state == ST_STREAM && hs && !bus.reload_tlast);
    assign raddr = (state == ST_PRIME) ? '0 : rd_addr;
    assign bus.busy = state != ST_IDLE || pending;
    ram_2port #(
        .W(COEFF_WIDTH),
        .DEPTH(N_LOAD),
        .AW(AW),
        .NUM_COEFFS(NUM_COEFFS),
        .INIT_VEC(COEFFS_VEC)
    ) u_ram (
        .clk(clk),
        .reset_n(reset_n),
        .we(wr_ok),
        .waddr(bus.cfg_wr_addr),
        .wdata(bus.cfg_wr_data),
        .re(re),
        .raddr(raddr),
        .rdata(bus.reload_tdata)
    );
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= ST_IDLE;
            pending           <= 1'b0;
            auto_q            <= AUTO_LOAD != 0;
            rd_addr           <= '0;
            bus.reload_tvalid <= 1'b0;
            bus.reload_tlast  <= 1'b0;
            bus.done          <= 1'b0;
            bus.cfg_wr_err    <= 1'b0;
        end else begin
            bus.cfg_wr_err <= bus.cfg_wr_en && !wr_ok;
            bus.done       <= state == ST_STREAM && hs && bus.reload_tlast;
            auto_q         <= 1'b0;
            pending        <= (state == ST_DONE) ? 1'b0 : pending || (bus.cfg_commit && state != ST_IDLE);
            if (re) begin
                rd_addr          <= raddr + 1'b1;
                bus.reload_tlast <= raddr == AW'(N_LOAD-1);
            end
            case (state)
                ST_IDLE:   if (bus.cfg_commit || auto_q) state <= ST_PRIME;
                ST_PRIME: begin
                    state             <= ST_STREAM;
                    bus.reload_tvalid <= 1'b1;
                end
                ST_STREAM: if (hs && bus.reload_tlast) begin
                    state             <= ST_DONE;
                    bus.reload_tvalid <= 1'b0;
                    bus.reload_tlast  <= 1'b0;
                end
                default:   state <= (pending || bus.cfg_commit) ? ST_PRIME : ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fir_coeff_loader.sv
// tb_fir_coeff_loader: randomized scenarios against a shadow-array model of the loader (8 taps symmetric, plus a 6-tap instance)
module tb_fir_coeff_loader;
    localparam int CW = 16;
    localparam int N = 4;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;
    fir_coeff_loader_if #(.COEFF_WIDTH(CW), .AW(2)) bus ();
    fir_coeff_loader_if #(.COEFF_WIDTH(CW), .AW(3)) bus2 ();
    fir_coeff_loader #(.COEFF_WIDTH(CW), .NUM_COEFFS(8), .SYMMETRIC(1), .AUTO_LOAD(1)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );
    fir_coeff_loader #(.COEFF_WIDTH(CW), .NUM_COEFFS(6), .SYMMETRIC(0), .AUTO_LOAD(0)) dut2 (
        .clk(clk), .reset_n(reset_n), .bus(bus2)
    );
    int tests = 0;
    int fails = 0;
    int cyc, rmode, done_cnt, done_cyc, err_cnt, first_valid;
    bit tgl, p_valid, p_hs, p_last;
    logic [CW-1:0] p_data;
    logic [CW-1:0] q_data [$];
    bit q_last [$];
    logic [CW-1:0] shadow [N];
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
    task automatic start_window();
        cyc = 0;
        done_cnt = 0;
        done_cyc = -1;
        err_cnt = 0;
        first_valid = -1;
        p_valid = 0;
        q_data.delete();
        q_last.delete();
    endtask
    // One cycle: drive ready, record beats/pulses, and hold the AXI stability rules
    task automatic step();
        @(negedge clk);
        cyc++;
        bus.cfg_wr_en = 1'b0;
        bus.cfg_commit = 1'b0;
        bus2.cfg_wr_en = 1'b0;
        tgl = !tgl;
        bus.reload_tready = (rmode == 0) ? 1'b1 : (rmode == 1) ? tgl : 1'($urandom_range(0, 1));
        if (bus.reload_tvalid && first_valid < 0) first_valid = cyc;
        if (bus.done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (bus.cfg_wr_err) err_cnt++;
        if (p_valid && !p_hs) begin
            tests++;
            if (bus.reload_tvalid !== 1'b1 || bus.reload_tdata !== p_data || bus.reload_tlast !== p_last) begin
                fails++;
                $display("FAIL stall_hold cyc %0d: valid %b data %h last %b, required 1 %h %b",
                         cyc, bus.reload_tvalid, bus.reload_tdata, bus.reload_tlast, p_data, p_last);
            end
        end else if (p_valid && !p_last) begin
            tests++;
            if (bus.reload_tvalid !== 1'b1) begin
                fails++;
                $display("FAIL valid_gap cyc %0d: valid %b, required 1", cyc, bus.reload_tvalid);
            end
        end
        p_valid = bus.reload_tvalid;
        p_hs = bus.reload_tvalid && bus.reload_tready;
        p_data = bus.reload_tdata;
        p_last = bus.reload_tlast;
        if (p_hs) begin
            q_data.push_back(bus.reload_tdata);
            q_last.push_back(bus.reload_tlast);
        end
    endtask
    task automatic write(input int addr, input logic [CW-1:0] data);
        step();
        bus.cfg_wr_en = 1'b1;
        bus.cfg_wr_addr = 2'(addr);
        bus.cfg_wr_data = data;
    endtask
    task automatic wait_done(input int n, input int budget, input string name);
        int k = 0;
        while (done_cnt < n && k < budget) begin
            step();
            k++;
        end
        tests++;
        if (done_cnt < n) begin
            fails++;
            $display("FAIL %s_timeout: done pulses %0d, required %0d", name, done_cnt, n);
        end
        repeat (3) step();
    endtask
    task automatic test_reset();
        bus.cfg_wr_en = 0; bus.cfg_commit = 0; bus.cfg_wr_addr = '0; bus.cfg_wr_data = '0;
        bus.reload_tready = 1'b1;
        bus2.cfg_wr_en = 0; bus2.cfg_commit = 0; bus2.cfg_wr_addr = '0; bus2.cfg_wr_data = '0;
        bus2.reload_tready = 1'b1;
        shadow = '{16'h7FFF, 16'h0, 16'h0, 16'h0};
        repeat (3) @(negedge clk);
        tests++;
        if ({bus.reload_tvalid, bus.reload_tlast, bus.busy, bus.done, bus.cfg_wr_err} !== 5'b0) begin
            fails++;
            $display("FAIL reset_flags: valid/last/busy/done/err %b, required 00000",
                     {bus.reload_tvalid, bus.reload_tlast, bus.busy, bus.done, bus.cfg_wr_err});
        end
        tests++;
        if (bus.reload_tdata !== '0) begin
            fails++;
            $display("FAIL reset_tdata: got %h, required 0000", bus.reload_tdata);
        end
    endtask
    task automatic check_packet(input string name, input int beats);
        tests++;
        if (q_data.size() != beats) begin
            fails++;
            $display("FAIL %s_len: got %0d beats, required %0d", name, q_data.size(), beats);
        end
        for (int i = 0; i < q_data.size() && i < beats; i++) begin
            tests++;
            if (q_data[i] !== shadow[i % N] || q_last[i] !== (i % N == N - 1)) begin
                fails++;
                $display("FAIL %s_beat%0d: data %h last %b, required %h %b",
                         name, i, q_data[i], q_last[i], shadow[i % N], i % N == N - 1);
            end
        end
    endtask
    task automatic test_auto_load();
        rmode = 0;
        reset_n = 1'b1;
        start_window();
        wait_done(1, 20, "auto");
        check_packet("auto", N);
        tests++;
        if (first_valid != 2 || done_cyc != 6 || done_cnt != 1) begin
            fails++;
            $display("FAIL auto_timing: first valid %0d done at %0d count %0d, required 2 6 1",
                     first_valid, done_cyc, done_cnt);
        end
    endtask
    task automatic test_write_toggle();
        rmode = 1;
        start_window();
        for (int i = 0; i < N; i++) begin
            write(i, CW'(i + 1));
            shadow[i] = CW'(i + 1);
        end
        step();
        bus.cfg_commit = 1'b1;
        wait_done(1, 40, "toggle");
        check_packet("toggle", N);
        tests++;
        if (done_cnt != 1 || err_cnt != 0) begin
            fails++;
            $display("FAIL toggle_pulses: done %0d err %0d, required 1 0", done_cnt, err_cnt);
        end
    endtask
    task automatic test_latency_random();
        int c0;
        rmode = 0;
        start_window();
        for (int i = 0; i < N; i++) begin
            shadow[i] = CW'($urandom);
            write(i, shadow[i]);
        end
        step();
        bus.cfg_commit = 1'b1;
        c0 = cyc;
        step();
        tests++;
        if (bus.busy !== 1'b1 || bus.reload_tvalid !== 1'b0) begin
            fails++;
            $display("FAIL latency_busy: busy %b valid %b, required 1 0", bus.busy, bus.reload_tvalid);
        end
        wait_done(1, 20, "latency");
        check_packet("latency", N);
        tests++;
        if (first_valid != c0 + 2 || done_cyc != c0 + N + 2) begin
            fails++;
            $display("FAIL latency_cycles: first valid +%0d done +%0d, required +2 +%0d",
                     first_valid - c0, done_cyc - c0, N + 2);
        end
    endtask
    task automatic test_wr_err();
        int k = 0;
        step();
        bus2.cfg_wr_en = 1'b1;
        bus2.cfg_wr_addr = 3'd5;
        bus2.cfg_wr_data = CW'($urandom);
        step();
        tests++;
        if (bus2.cfg_wr_err !== 1'b0) begin
            fails++;
            $display("FAIL err_inrange: got %b, required 0", bus2.cfg_wr_err);
        end
        bus2.cfg_wr_en = 1'b1;
        bus2.cfg_wr_addr = 3'($urandom_range(6, 7));
        step();
        tests++;
        if (bus2.cfg_wr_err !== 1'b1) begin
            fails++;
            $display("FAIL err_outrange: got %b, required 1", bus2.cfg_wr_err);
        end
        step();
        tests++;
        if (bus2.cfg_wr_err !== 1'b0) begin
            fails++;
            $display("FAIL err_oneshot: got %b, required 0", bus2.cfg_wr_err);
        end
        rmode = 2;
        start_window();
        step();
        bus.cfg_commit = 1'b1;
        while (first_valid < 0 && k < 10) begin
            step();
            k++;
        end
        bus.cfg_wr_en = 1'b1;
        bus.cfg_wr_addr = 2'($urandom_range(0, N - 1));
        bus.cfg_wr_data = ~shadow[bus.cfg_wr_addr];
        wait_done(1, 40, "stream_wr");
        check_packet("stream_wr", N);
        tests++;
        if (err_cnt != 1) begin
            fails++;
            $display("FAIL stream_wr_err: %0d pulses, required 1", err_cnt);
        end
        rmode = 0;
        start_window();
        step();
        bus.cfg_commit = 1'b1;
        wait_done(1, 20, "unchanged");
        check_packet("unchanged", N);
    endtask
    task automatic test_back_to_back();
        int k = 0;
        int gap = 0;
        int extra = 0;
        rmode = 2;
        start_window();
        step();
        bus.cfg_commit = 1'b1;
        while (done_cnt < 2 && k < 80) begin
            step();
            k++;
            if (!bus.busy) gap++;
            if (first_valid > 0 && extra < 3) begin
                bus.cfg_commit = 1'b1;
                extra++;
            end
        end
        tests++;
        if (done_cnt < 2) begin
            fails++;
            $display("FAIL b2b_timeout: done pulses %0d, required 2", done_cnt);
        end
        repeat (8) step();
        check_packet("b2b", 2 * N);
        tests++;
        if (gap != 0 || done_cnt != 2 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL b2b_busy: busy gaps %0d done %0d final busy %b, required 0 2 0", gap, done_cnt, bus.busy);
        end
    endtask
    task automatic test_same_cycle();
        rmode = 2;
        start_window();
        write(2, 16'h1234);
        bus.cfg_commit = 1'b1;
        shadow[2] = 16'h1234;
        wait_done(1, 40, "same_cycle");
        check_packet("same_cycle", N);
    endtask
    task automatic test_reset_mid();
        int k = 0;
        rmode = 0;
        for (int i = 0; i < N; i++) begin
            shadow[i] = CW'($urandom);
            write(i, shadow[i]);
        end
        start_window();
        step();
        bus.cfg_commit = 1'b1;
        while (q_data.size() < 3 && k < 20) begin
            step();
            k++;
        end
        #2 reset_n = 1'b0;
        #1;
        tests++;
        if ({bus.reload_tvalid, bus.reload_tlast, bus.busy} !== 3'b0 || bus.reload_tdata !== '0) begin
            fails++;
            $display("FAIL mid_reset: valid/last/busy %b data %h, required 000 0000",
                     {bus.reload_tvalid, bus.reload_tlast, bus.busy}, bus.reload_tdata);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        start_window();
        wait_done(1, 20, "replay");
        check_packet("replay", N);
        tests++;
        if (done_cyc != 6) begin
            fails++;
            $display("FAIL replay_done_cycle: got %0d, required 6", done_cyc);
        end
    endtask
    initial begin
        test_reset();
        test_auto_load();
        test_write_toggle();
        test_latency_random();
        test_wr_err();
        test_back_to_back();
        test_same_cycle();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
